// File: rtl/lm_sm_sequencer_if.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer_if
//   Bundles the fetch-side instruction handshake and the micro-op bus that
//   leaves the LM/SM decode-stage sequencer.
//
//   Fetch side : IR_in, valid_in, stall_in, flush  (into the sequencer)
//                hold_fetch                         (out of the sequencer)
//   Micro-op   : uop_valid, uop_IR, uop_is_load, uop_is_store,
//                uop_base_reg, uop_data_reg, uop_offset, uop_last
//
//   modport slave  : the sequencer itself
//   modport master : the surrounding pipeline (fetch/decode and address gen)
// ---------------------------------------------------------------------------
interface lm_sm_sequencer_if;
  logic [15:0] IR_in;
  logic        valid_in;
  logic        stall_in;
  logic        flush;
  logic        hold_fetch;

  logic        uop_valid;
  logic [15:0] uop_IR;
  logic        uop_is_load;
  logic        uop_is_store;
  logic [2:0]  uop_base_reg;
  logic [2:0]  uop_data_reg;
  logic [15:0] uop_offset;
  logic        uop_last;

  modport slave (
    input  IR_in, valid_in, stall_in, flush,
    output hold_fetch,
    output uop_valid, uop_IR, uop_is_load, uop_is_store,
    output uop_base_reg, uop_data_reg, uop_offset, uop_last
  );

  modport master (
    output IR_in, valid_in, stall_in, flush,
    input  hold_fetch,
    input  uop_valid, uop_IR, uop_is_load, uop_is_store,
    input  uop_base_reg, uop_data_reg, uop_offset, uop_last
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer
//   Decode-stage micro-sequencer. A load-multiple / store-multiple
//   instruction is expanded into one single-register micro-op per selected
//   register (R0 first); every other instruction passes straight through.
//   Fetch is held while an expansion is still running.
//
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     rst_n  : synchronous active-low reset
//     bus    : lm_sm_sequencer_if.slave
//              in : IR_in, valid_in, stall_in, flush
//              out: hold_fetch (combinational), uop_* (registered)
//
//   Priority at each edge: reset, flush, stall_in, normal operation.
// ---------------------------------------------------------------------------
module lm_sm_sequencer #(
  parameter logic [3:0]  LM_OPCODE   = 4'b0110,
  parameter logic [3:0]  SM_OPCODE   = 4'b0111,
  parameter int unsigned OFFSET_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  lm_sm_sequencer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  // Sequencer state
  state_t      state_q, state_d;
  logic [7:0]  mask_q,  mask_d;   // bit k set => Rk still to be transferred
  logic [2:0]  index_q, index_d;  // transfer number of the next emission
  logic [15:0] ir_q,    ir_d;     // instruction being expanded

  // Registered micro-op outputs
  logic        uv_q,    uv_d;
  logic [15:0] uir_q,   uir_d;
  logic        ld_q,    ld_d;
  logic        st_q,    st_d;
  logic [2:0]  base_q,  base_d;
  logic [2:0]  data_q,  data_d;
  logic [15:0] off_q,   off_d;
  logic        last_q,  last_d;

  // Lowest set bit of an 8-bit vector (0 when empty; callers guard that case).
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) lowest_set = 3'(k);
    end
  endfunction

  // The instruction encodes Rk at IR[7-k]; flip it so bit k means Rk.
  function automatic logic [7:0] list_to_regs(input logic [7:0] list);
    for (int k = 0; k < 8; k++) begin
      list_to_regs[k] = list[7-k];
    end
  endfunction

  logic [3:0]  opcode;
  logic        is_lm, is_sm;
  logic [7:0]  list_regs;
  logic [2:0]  first_k;
  logic [7:0]  first_rest;
  logic [2:0]  seq_k;
  logic [7:0]  seq_rest;
  logic [15:0] seq_offset;

  assign opcode     = bus.IR_in[15:12];
  assign is_lm      = (opcode == LM_OPCODE);
  assign is_sm      = (opcode == SM_OPCODE);
  assign list_regs  = list_to_regs(bus.IR_in[7:0]);
  assign first_k    = lowest_set(list_regs);
  assign first_rest = list_regs & ~(8'b1 << first_k);
  assign seq_k      = lowest_set(mask_q);
  assign seq_rest   = mask_q & ~(8'b1 << seq_k);
  // Computed wide, then truncated to the 16-bit offset bus (wraps mod 2^16).
  assign seq_offset = 16'(32'(index_q) * OFFSET_STEP);

  assign bus.hold_fetch = bus.stall_in | (state_q == SEQ);

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case/if tree leaves one unassigned, which would infer a latch.
    state_d = state_q;
    mask_d  = mask_q;
    index_d = index_q;
    ir_d    = ir_q;
    uv_d    = uv_q;
    uir_d   = uir_q;
    ld_d    = ld_q;
    st_d    = st_q;
    base_d  = base_q;
    data_d  = data_q;
    off_d   = off_q;
    last_d  = last_q;

    if (bus.flush) begin
      // Kill any expansion; the other micro-op fields keep their last values.
      state_d = IDLE;
      mask_d  = 8'd0;
      uv_d    = 1'b0;
    end else if (!bus.stall_in) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.valid_in) begin
            uv_d = 1'b0;
          end else if (is_lm || is_sm) begin
            ir_d = bus.IR_in;
            if (list_regs == 8'd0) begin
              // Empty register list: nothing to transfer.
              uv_d = 1'b0;
            end else begin
              uv_d    = 1'b1;
              uir_d   = bus.IR_in;
              ld_d    = is_lm;
              st_d    = is_sm;
              base_d  = bus.IR_in[11:9];
              data_d  = first_k;
              off_d   = 16'd0;
              mask_d  = first_rest;
              index_d = 3'd1;
              last_d  = (first_rest == 8'd0);
              state_d = (first_rest == 8'd0) ? IDLE : SEQ;
            end
          end else begin
            // Pass-through of any non LM/SM instruction.
            ir_d   = bus.IR_in;
            uv_d   = 1'b1;
            uir_d  = bus.IR_in;
            ld_d   = 1'b0;
            st_d   = 1'b0;
            base_d = 3'd0;
            data_d = 3'd0;
            off_d  = 16'd0;
            last_d = 1'b1;
          end
        end

        SEQ: begin
          // IR_in is ignored here; fetch is being held.
          uv_d    = 1'b1;
          uir_d   = ir_q;
          data_d  = seq_k;
          off_d   = seq_offset;
          mask_d  = seq_rest;
          // At most 8 transfers, so index tops out at 7 on the last one and
          // the wrap of this increment is never observed.
          index_d = index_q + 3'd1;
          last_d  = (seq_rest == 8'd0);
          state_d = (seq_rest == 8'd0) ? IDLE : SEQ;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
      index_q <= 3'd0;
      ir_q    <= 16'd0;
      uv_q    <= 1'b0;
      uir_q   <= 16'd0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      base_q  <= 3'd0;
      data_q  <= 3'd0;
      off_q   <= 16'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      index_q <= index_d;
      ir_q    <= ir_d;
      uv_q    <= uv_d;
      uir_q   <= uir_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      base_q  <= base_d;
      data_q  <= data_d;
      off_q   <= off_d;
      last_q  <= last_d;
    end
  end

  assign bus.uop_valid    = uv_q;
  assign bus.uop_IR       = uir_q;
  assign bus.uop_is_load  = ld_q;
  assign bus.uop_is_store = st_q;
  assign bus.uop_base_reg = base_q;
  assign bus.uop_data_reg = data_q;
  assign bus.uop_offset   = off_q;
  assign bus.uop_last     = last_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lm_sm_sequencer
//   Directed, table-driven bench for lm_sm_sequencer. Each table row holds the
//   inputs applied for one clock edge and the outputs expected after it.
//   A second instance with OFFSET_STEP=2 runs a hand-written LM sequence.
// ---------------------------------------------------------------------------
module tb_lm_sm_sequencer;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;

  always #5 clk = ~clk;

  lm_sm_sequencer_if bus1 ();
  lm_sm_sequencer_if bus2 ();

  lm_sm_sequencer #(.OFFSET_STEP(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus1.slave)
  );

  lm_sm_sequencer #(.OFFSET_STEP(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus2.slave)
  );

  // Packed micro-op bundle: {valid, IR, load, store, base, data, offset, last}
  typedef logic [41:0] uop_t;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        valid;
    logic [15:0] ir;
    logic        stall;
    logic        flush;
    logic        exp_hold;
    uop_t        exp_uop;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic uop_t xf(input logic [15:0] ir, input logic ld, input logic st,
                              input logic [2:0] base, input logic [2:0] data,
                              input logic [15:0] off, input logic last);
    xf = {1'b1, ir, ld, st, base, data, off, last};
  endfunction

  function automatic uop_t pass(input logic [15:0] ir);
    pass = xf(ir, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 1'b1);
  endfunction

  function automatic uop_t novalid(input uop_t u);
    novalid = u;
    novalid[41] = 1'b0;
  endfunction

  task automatic add(input string n, input logic r, input logic v, input logic [15:0] ir,
                     input logic s, input logic f, input logic h, input uop_t u);
    vec_t x;
    x.name = n; x.rst_n = r; x.valid = v; x.ir = ir; x.stall = s; x.flush = f;
    x.exp_hold = h; x.exp_uop = u;
    vecs.push_back(x);
  endtask

  function automatic uop_t sample1();
    sample1 = {bus1.uop_valid, bus1.uop_IR, bus1.uop_is_load, bus1.uop_is_store,
               bus1.uop_base_reg, bus1.uop_data_reg, bus1.uop_offset, bus1.uop_last};
  endfunction

  initial begin
    uop_t lm0;
    lm0 = xf(16'h64A1, 1'b1, 1'b0, 3'd2, 3'd0, 16'd0, 1'b0);

    bus1.IR_in = '0; bus1.valid_in = 1'b0; bus1.stall_in = 1'b0; bus1.flush = 1'b0;
    bus2.IR_in = '0; bus2.valid_in = 1'b0; bus2.stall_in = 1'b0; bus2.flush = 1'b0;

    // ---------------- vector table ----------------
    // Reset (valid instruction present but must be ignored), then pass-through.
    add("rst_a",  1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, '0);
    add("rst_b",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, '0);
    add("pass",   1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, pass(16'h1234));
    add("idle",   1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, novalid(pass(16'h1234)));
    // LM R2,{R0,R2,R7}; the next instruction 0x5555 waits while hold_fetch=1.
    add("lm0",    1'b1, 1'b1, 16'h64A1, 1'b0, 1'b0, 1'b1, lm0);
    add("lm1",    1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, xf(16'h64A1, 1, 0, 3'd2, 3'd2, 16'd1, 0));
    add("lm2",    1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, xf(16'h64A1, 1, 0, 3'd2, 3'd7, 16'd2, 1));
    add("lm_next",1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, pass(16'h5555));
    // SM R5 with full list: R0..R7, offsets 0..7.
    for (int k = 0; k < 8; k++)
      add($sformatf("sm_full%0d", k), 1'b1, 1'b1, 16'h7AFF, 1'b0, 1'b0, (k < 7),
          xf(16'h7AFF, 0, 1, 3'd5, 3'(k), 16'(k), (k == 7)));
    // SM with empty list: no micro-op, no hold.
    add("sm_empty", 1'b1, 1'b1, 16'h7A00, 1'b0, 1'b0, 1'b0,
        novalid(xf(16'h7AFF, 0, 1, 3'd5, 3'd7, 16'd7, 1)));
    // Stall for 3 cycles after the first LM micro-op.
    add("st_lm0", 1'b1, 1'b1, 16'h64A1, 1'b0, 1'b0, 1'b1, lm0);
    for (int k = 0; k < 3; k++)
      add($sformatf("stall%0d", k), 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, lm0);
    add("st_lm1", 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, xf(16'h64A1, 1, 0, 3'd2, 3'd2, 16'd1, 0));
    add("st_lm2", 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, xf(16'h64A1, 1, 0, 3'd2, 3'd7, 16'd2, 1));
    // Stall while idle freezes outputs and raises hold_fetch.
    add("stall_idle", 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1,
        xf(16'h64A1, 1, 0, 3'd2, 3'd7, 16'd2, 1));
    // Flush outranks stall mid-expansion.
    add("fs_lm0",   1'b1, 1'b1, 16'h64A1, 1'b0, 1'b0, 1'b1, lm0);
    add("fs_flush", 1'b1, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, novalid(lm0));
    add("fs_after", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, novalid(lm0));
    // Flush after the 3rd SM micro-op.
    for (int k = 0; k < 3; k++)
      add($sformatf("fl_sm%0d", k), 1'b1, 1'b1, 16'h7AFF, 1'b0, 1'b0, 1'b1,
          xf(16'h7AFF, 0, 1, 3'd5, 3'(k), 16'(k), 0));
    add("flush",       1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0,
        novalid(xf(16'h7AFF, 0, 1, 3'd5, 3'd2, 16'd2, 0)));
    add("after_flush", 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, pass(16'h1234));
    // Reset after the 3rd SM micro-op.
    for (int k = 0; k < 3; k++)
      add($sformatf("rs_sm%0d", k), 1'b1, 1'b1, 16'h7AFF, 1'b0, 1'b0, 1'b1,
          xf(16'h7AFF, 0, 1, 3'd5, 3'(k), 16'(k), 0));
    add("mid_rst",   1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, '0);
    add("after_rst", 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, pass(16'h1234));

    // ---------------- apply table ----------------
    foreach (vecs[i]) begin
      rst_n_a       = vecs[i].rst_n;
      bus1.valid_in = vecs[i].valid;
      bus1.IR_in    = vecs[i].ir;
      bus1.stall_in = vecs[i].stall;
      bus1.flush    = vecs[i].flush;
      @(posedge clk);
      @(negedge clk);
      check({vecs[i].name, "_uop"},  64'(sample1()),       64'(vecs[i].exp_uop));
      check({vecs[i].name, "_hold"}, 64'(bus1.hold_fetch), 64'(vecs[i].exp_hold));
    end

    // ---------------- OFFSET_STEP=2 instance ----------------
    begin
      logic [15:0] offs [3];
      logic [2:0]  regs [3];
      int          n;
      bit          done;
      n = 0;
      done = 1'b0;
      rst_n_b = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n_b = 1'b1;
      bus2.IR_in = 16'h64A1;
      bus2.valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus2.valid_in = 1'b0;
      bus2.IR_in = 16'h0000;
      // Collect emissions until the last one, bounded to 8 cycles.
      for (int c = 0; c < 8 && !done; c++) begin
        if (bus2.uop_valid) begin
          if (n < 3) begin
            offs[n] = bus2.uop_offset;
            regs[n] = bus2.uop_data_reg;
          end
          n++;
          if (bus2.uop_last) done = 1'b1;
        end
        if (!done) begin
          @(posedge clk);
          @(negedge clk);
        end
      end
      check("step2_done",  64'(done), 64'(1));
      check("step2_count", 64'(n),    64'(3));
      for (int i = 0; i < 3; i++) begin
        check($sformatf("step2_off%0d", i), 64'(offs[i]), 64'(2 * i));
      end
      check("step2_reg0", 64'(regs[0]), 64'(0));
      check("step2_reg1", 64'(regs[1]), 64'(2));
      check("step2_reg2", 64'(regs[2]), 64'(7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Decode-stage micro-sequencer for the 16-bit pipeline.
- Expands each load-multiple (LM) or store-multiple (SM) instruction into one single-register micro-op per set bit of its 8-bit register list.
- Every other instruction passes through unchanged.
- Stalls instruction fetch while an expansion is in progress, and supplies the per-transfer base register, data register and offset that the address-generation datapath consumes.

Parameters:
LM_OPCODE, 4'b0110, opcode value decoded as load-multiple
SM_OPCODE, 4'b0111, opcode value decoded as store-multiple
OFFSET_STEP, 1, address increment per transfer; uop_offset = transfer_index * OFFSET_STEP

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
IR_in  input  16  instruction from fetch/decode register
valid_in  input  1  IR_in holds a valid instruction
stall_in  input  1  downstream hazard stall; freezes this block
flush  input  1  branch/jump flush; kills in-flight expansion
hold_fetch  output  1  combinational; upstream must hold IR_in/valid_in
uop_valid  output  1  registered; micro-op outputs valid
uop_IR  output  16  registered; original instruction word
uop_is_load  output  1  registered; micro-op is an LM transfer
uop_is_store  output  1  registered; micro-op is an SM transfer
uop_base_reg  output  3  registered; RA = IR[11:9] of the LM/SM
uop_data_reg  output  3  registered; register transferred by this micro-op
uop_offset  output  16  registered; zero-extended transfer_index*OFFSET_STEP
uop_last  output  1  registered; final micro-op of this instruction (1 for pass-through)

Behaviour:
- Register list encoding: list = IR[7:0], where bit IR[7-k] selects Rk. Transfers are issued in ascending k (R0 first).
- States: IDLE and SEQ. Internal state: latched IR, remaining mask (8 bits), transfer index (3 bits).
- Priority order at each edge: rst_n low, then flush, then stall_in, then normal operation.
- Reset (rst_n=0 at an edge):
  - state goes to IDLE; mask, index and latched IR are cleared.
  - All outputs return to 0. hold_fetch follows stall_in.
  - Reset mid-expansion abandons the remaining transfers.
- flush=1 (with rst_n=1):
  - state goes to IDLE, mask is cleared, uop_valid goes to 0 next cycle; other output registers hold.
  - IR_in is not accepted that cycle.
- stall_in=1: all registers hold, including outputs, state and mask.
- IDLE, valid_in=0: uop_valid goes to 0 next cycle.
- IDLE, valid_in=1, opcode is neither LM nor SM:
  - Next cycle: uop_valid=1, uop_IR=IR_in, uop_last=1.
  - uop_is_load, uop_is_store and uop_offset are 0.
  - uop_base_reg and uop_data_reg are 0.
- IDLE, LM/SM with list=0: treated as a no-op. uop_valid goes to 0 and state stays IDLE.
- IDLE, LM/SM with list≠0:
  - Let k = lowest selected register. Next cycle: uop_valid=1, uop_IR=IR_in, uop_is_load/uop_is_store per opcode, uop_base_reg=IR[11:9], uop_data_reg=k, uop_offset=0.
  - mask is set to list with Rk cleared; index is set to 1.
  - If mask is now 0: uop_last=1 and state stays IDLE. Otherwise uop_last=0 and state goes to SEQ.
- SEQ, per non-stalled cycle:
  - Emit the next lowest selected register from mask with uop_offset=index*OFFSET_STEP, then clear that bit and increment index.
  - On the emission where mask becomes 0: uop_last=1 and state goes to IDLE.
  - IR_in is ignored while in SEQ.
- hold_fetch = stall_in OR (state==SEQ). An instruction is accepted only on an edge where hold_fetch=0 and flush=0.
- Timing: latency is 1 cycle. An LM/SM with n selected registers produces n consecutive micro-ops when there are no stalls. The following instruction is accepted in the cycle after the last micro-op is emitted, i.e. it is held for n-1 cycles.
- Arithmetic width: index is 3 bits and never wraps, since there are at most 8 transfers (index reaches 7 on the 8th transfer). uop_offset is computed at 16 bits and truncates mod 2^16.
- OFFSET_STEP's effect on the emitted offsets is per the uop_offset formula above.

Test Plan:
- Reset, then pass-through: hold rst_n=0 for 2 cycles, then send ADD IR=0x1234 with valid_in=1.
  - During reset all outputs are 0.
  - One cycle after the instruction is sent: uop_valid=1, uop_IR=0x1234, uop_last=1, uop_is_load=0, uop_is_store=0, hold_fetch=0.
- LM expansion: IR=0x64A1 (RA=R2, list selects R0, R2 and R7).
  - Three consecutive micro-ops with uop_is_load=1, uop_base_reg=2:
    - data_reg 0, offset 0, last 0
    - data_reg 2, offset 1, last 0
    - data_reg 7, offset 2, last 1
  - hold_fetch is high for exactly 2 cycles. The next instruction appears one cycle after the last micro-op.
- SM full list and empty list:
  - IR=0x7AFF gives 8 micro-ops with uop_is_store=1, base 5, data_reg 0..7, offsets 0..7; only the 8th has uop_last=1.
  - IR=0x7A00 gives uop_valid=0 and no hold_fetch.
- Stall mid-expansion: during 0x64A1, assert stall_in for 3 cycles after the first micro-op.
  - Outputs are frozen at data_reg 0 during the stall.
  - The sequence then resumes R2 then R7 with no transfer skipped or duplicated.
- Flush and reset mid-expansion: during 0x7AFF, assert flush after the 3rd micro-op.
  - uop_valid=0 next cycle, state is IDLE, and the next instruction is accepted with no further transfers.
  - Repeat with rst_n=0 in place of flush: same outcome, and all outputs are 0.
- OFFSET_STEP=2 instance running 0x64A1: offsets are 0, 2, 4.
